mem_access_unit: RTL and testbench

- Word-addressed memory with a request/ready handshake, sitting directly downstream of the multicycle CPU's memory port.
- Consumes readM/writeM/address and the shared bidirectional data bus, and serves both instruction fetches and data accesses.
- Models a configurable access latency, so CPU control can be verified against a memory that does not answer in the same cycle.

---
 rtl/mem_access_unit_if.sv | 16 +
 rtl/mem_access_unit.sv | 64 ++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/ready handshake bundle between a CPU memory port and mem_access_unit
//   readM/writeM/address : request from the CPU (master)
//   mem_ready/busy       : access progress reported by the memory (slave)
//   req_error            : sticky flag for a request with both readM and writeM high
//   access_count         : number of completed accesses
interface mem_access_unit_if #(parameter int WORD_SIZE = 16);
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 mem_ready;
  logic                 busy;
  logic                 req_error;
  logic [WORD_SIZE-1:0] access_count;
  modport master (output readM, writeM, address, input mem_ready, busy, req_error, access_count);
  modport slave (input readM, writeM, address, output mem_ready, busy, req_error, access_count);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: word-addressed memory with a LATENCY-cycle request/ready handshake
//   clk, reset : clock and asynchronous active-high reset (storage is not cleared)
//   bus        : slave side of mem_access_unit_if (requests in, status out)
//   data       : shared bidirectional bus; write data in, read data driven only in DONE of a read
module mem_access_unit #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave bus,
  inout wire [WORD_SIZE-1:0] data
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic op_wr;
  logic [ADDR_BITS-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] rdata;
  logic [3:0] cnt;
  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];
  logic req, accept, commit, addr_unused;
  // upper address bits alias onto the same words
  assign addr_unused = ^bus.address;
  always_comb begin
    req = op_wr ? bus.writeM : bus.readM;
    accept = state == IDLE && (bus.readM ^ bus.writeM);
    commit = state == WAIT && req && cnt == 4'd0;
    // dropping the latched request aborts WAIT and ends DONE
    state_n = state == IDLE ? (accept ? WAIT : IDLE) :
              !req ? IDLE :
              (state == WAIT && cnt != 4'd0) ? WAIT : DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      cnt <= '0;
      bus.req_error <= 1'b0;
      bus.access_count <= '0;
    end else begin
      if (accept) begin
        op_wr <= bus.writeM;
        addr <= bus.address[ADDR_BITS-1:0];
        wdata <= data;
      end
      cnt <= accept ? 4'(LATENCY - 1) : state == WAIT ? cnt - 4'd1 : cnt;
      bus.req_error <= bus.req_error | (state == IDLE && bus.readM && bus.writeM);
      bus.access_count <= commit ? bus.access_count + 1'b1 : bus.access_count;
    end
  always_ff @(posedge clk)
    if (commit) begin
      if (op_wr) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
  assign bus.mem_ready = state == DONE;
  assign bus.busy = state == WAIT;
  assign data = (state == DONE && !op_wr && bus.readM && !bus.writeM) ? rdata : 'z;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit against an array reference model
module tb_mem_access_unit;
  localparam int W = 16;
  localparam int AB = 8;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mem_access_unit_if #(.WORD_SIZE(W)) bus ();
  mem_access_unit_if #(.WORD_SIZE(W)) bus1 ();
  wire [W-1:0] data;
  wire [W-1:0] data1;
  logic tb_en, tb_en1;
  logic [W-1:0] tb_wd, tb_wd1;
  assign data = tb_en ? tb_wd : 'z;
  assign data1 = tb_en1 ? tb_wd1 : 'z;
  mem_access_unit #(.WORD_SIZE(W), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .data(data));
  mem_access_unit #(.WORD_SIZE(W), .ADDR_BITS(AB), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .data(data1));
  logic [W-1:0] ref_mem [2**AB];
  int ref_cnt;
  logic ref_err;
  int tests = 0;
  int fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle_bus();
    bus.readM = 1'b0;
    bus.writeM = 1'b0;
    tb_en = 1'b0;
  endtask
  task automatic access(input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
    int k;
    logic [W-1:0] exp_rd;
    logic [AB-1:0] ia;
    ia = a[AB-1:0];
    exp_rd = ref_mem[ia];
    bus.readM = !wr;
    bus.writeM = wr;
    bus.address = a;
    tb_en = wr;
    tb_wd = d;
    @(negedge clk);
    check("accept_busy", {31'd0, bus.busy}, 1);
    bus.address = W'($urandom);
    tb_wd = W'($urandom);
    k = 0;
    while (!bus.mem_ready && k < 20) begin
      @(negedge clk);
      k++;
      if (!bus.mem_ready) check("wait_busy", {31'd0, bus.busy}, 1);
    end
    check("latency", k, LAT);
    if (wr) ref_mem[ia] = d;
    ref_cnt++;
    check("count", {16'd0, bus.access_count}, {16'd0, 16'(ref_cnt)});
    check("err_hold", {31'd0, bus.req_error}, {31'd0, ref_err});
    repeat ($urandom_range(2, 0)) begin
      if (!wr) check("rdata_hold", {16'd0, data}, {16'd0, exp_rd});
      @(negedge clk);
      check("ready_hold", {31'd0, bus.mem_ready}, 1);
    end
    if (!wr) check("rdata", {16'd0, data}, {16'd0, exp_rd});
    idle_bus();
    @(negedge clk);
    check("ready_drop", {31'd0, bus.mem_ready}, 0);
    check("idle_busy", {31'd0, bus.busy}, 0);
  endtask
  task automatic abort(input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
    bus.readM = !wr;
    bus.writeM = wr;
    bus.address = a;
    tb_en = wr;
    tb_wd = d;
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 1);
    repeat ($urandom_range(LAT - 2, 0)) begin
      @(negedge clk);
      check("abort_wait", {31'd0, bus.busy}, 1);
    end
    idle_bus();
    @(negedge clk);
    check("abort_ready", {31'd0, bus.mem_ready}, 0);
    check("abort_idle", {31'd0, bus.busy}, 0);
    check("abort_count", {16'd0, bus.access_count}, {16'd0, 16'(ref_cnt)});
  endtask
  task automatic both_high(input logic [W-1:0] a);
    bus.readM = 1'b1;
    bus.writeM = 1'b1;
    bus.address = a;
    tb_en = 1'b1;
    tb_wd = W'($urandom);
    @(negedge clk);
    ref_err = 1'b1;
    check("both_busy", {31'd0, bus.busy}, 0);
    check("both_ready", {31'd0, bus.mem_ready}, 0);
    check("both_err", {31'd0, bus.req_error}, 1);
    idle_bus();
    @(negedge clk);
    check("both_idle", {31'd0, bus.busy}, 0);
  endtask
  task automatic reset_mid_write(input logic [W-1:0] a, input logic [W-1:0] d);
    bus.writeM = 1'b1;
    bus.readM = 1'b0;
    bus.address = a;
    tb_en = 1'b1;
    tb_wd = d;
    @(negedge clk);
    check("rst_wait_busy", {31'd0, bus.busy}, 1);
    #2 reset = 1'b1;
    #1;
    ref_cnt = 0;
    ref_err = 1'b0;
    check("rst_ready", {31'd0, bus.mem_ready}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_err", {31'd0, bus.req_error}, 0);
    check("rst_count", {16'd0, bus.access_count}, 0);
    idle_bus();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int r;
    reset = 1'b1;
    idle_bus();
    bus.address = '0;
    bus1.readM = 1'b0;
    bus1.writeM = 1'b0;
    bus1.address = '0;
    tb_en1 = 1'b0;
    tb_wd1 = '0;
    tb_wd = '0;
    ref_cnt = 0;
    ref_err = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, bus.mem_ready}, 0);
    check("reset_busy", {31'd0, bus.busy}, 0);
    check("reset_err", {31'd0, bus.req_error}, 0);
    check("reset_count", {16'd0, bus.access_count}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2**AB; i++) access(1'b1, W'(i), i == 5 ? 16'h1234 : 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_cnt = 0;
    check("storage_reset_count", {16'd0, bus.access_count}, 0);
    access(1'b0, 16'h0005, '0);
    access(1'b1, 16'h0010, 16'hBEEF);
    access(1'b0, 16'h0010, '0);
    abort(1'b1, 16'h0020, 16'h00AA);
    access(1'b0, 16'h0020, '0);
    both_high(16'h0005);
    access(1'b0, 16'h0005, '0);
    access(1'b1, 16'h0103, 16'h5555);
    access(1'b0, 16'h0003, '0);
    reset_mid_write(16'h0030, 16'h7777);
    access(1'b0, 16'h0030, '0);
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(9, 0));
      if (r < 4) access(1'b1, W'($urandom), W'($urandom));
      else if (r < 8) access(1'b0, W'($urandom), '0);
      else if (r == 8) abort(1'($urandom), W'($urandom), W'($urandom));
      else both_high(W'($urandom));
    end
    bus1.writeM = 1'b1;
    bus1.address = 16'h0007;
    tb_en1 = 1'b1;
    tb_wd1 = 16'hA5A5;
    @(negedge clk);
    check("l1_wr_busy", {31'd0, bus1.busy}, 1);
    tb_wd1 = 16'h0F0F;
    @(negedge clk);
    check("l1_wr_ready", {31'd0, bus1.mem_ready}, 1);
    bus1.writeM = 1'b0;
    tb_en1 = 1'b0;
    @(negedge clk);
    check("l1_wr_drop", {31'd0, bus1.mem_ready}, 0);
    bus1.readM = 1'b1;
    bus1.address = 16'h0107;
    @(negedge clk);
    check("l1_rd_busy", {31'd0, bus1.busy}, 1);
    @(negedge clk);
    check("l1_rd_ready", {31'd0, bus1.mem_ready}, 1);
    check("l1_rd_data", {16'd0, data1}, 32'h0000A5A5);
    check("l1_count", {16'd0, bus1.access_count}, 2);
    bus1.readM = 1'b0;
    @(negedge clk);
    check("l1_rd_drop", {31'd0, bus1.mem_ready}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
